// File: rtl/vram_pkg.sv
// Shared types and defaults for the frame-buffer arbiter slice.
package vram_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_ADDR_W     = 20;
  localparam int DEFAULT_PIX_W      = 3;

  typedef logic [DEFAULT_PIX_W-1:0]  pix_t;
  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and occupancy; the head entry is
// presented combinationally, so a push in one cycle can pop in the next.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign level     = level_r;
  assign head      = mem_r[rd_ptr_r];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: scan-out reads, queued pixel writes and a fill
// engine. Define VRAM_ARB_CLEAR_SYNC_EN to defer clears to the next frame_end.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int PIX_W      = DEFAULT_PIX_W
) (
  input  logic                              vclk,
  input  logic                              srst,
  input  logic [9:0]                        width,
  input  logic [9:0]                        height,
  input  logic                              visible,
  input  logic                              frame_end,
  input  logic [ADDR_W-1:0]                 scan_addr,
  output logic [PIX_W-1:0]                  pixel,
  input  logic                              wr_valid,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [PIX_W-1:0]                  wr_data,
  output logic                              wr_ready,
  input  logic                              clear_start,
  input  logic [PIX_W-1:0]                  clear_color,
  output logic                              busy,
  output logic                              clear_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic                              ram_we,
  output logic [PIX_W-1:0]                  ram_wdata,
  input  logic [PIX_W-1:0]                  ram_rdata
);

  arb_state_t              state_r;
  logic                    busy_r;
  logic                    clear_done_r;
  logic [19:0]             clr_addr_r;
  logic [19:0]             clr_len_r;
  logic [PIX_W-1:0]        clr_color_r;
  logic                    full_s;
  logic                    empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    clr_run_s;
  logic [ADDR_W+PIX_W-1:0] head_s;
  logic [ADDR_W-1:0]       head_addr_s;
  logic [PIX_W-1:0]        head_data_s;

`ifndef VRAM_ARB_CLEAR_SYNC_EN
  logic unused_frame_end_s;
  assign unused_frame_end_s = frame_end;
`endif

  assign wr_ready    = !full_s && !srst;
  assign push_s      = wr_valid && wr_ready;
  assign head_addr_s = head_s[ADDR_W+PIX_W-1:PIX_W];
  assign head_data_s = head_s[PIX_W-1:0];
  assign clr_run_s   = (state_r == CLEAR) && (clr_len_r != 20'd0);
  assign pixel       = ram_rdata;
  assign busy        = busy_r;
  assign clear_done  = clear_done_r;

  sync_fifo #(
    .WIDTH (ADDR_W + PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (vclk),
    .srst  (srst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({wr_addr, wr_data}),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  // RAM port mux; queued writes wait while a clear is armed or running so they land on top of it.
  always_comb begin
    ram_addr  = scan_addr;
    ram_we    = 1'b0;
    ram_wdata = head_data_s;
    pop_s     = 1'b0;
    if (srst) begin
      ram_we = 1'b0;
    end else if (visible) begin
      ram_addr = scan_addr;
    end else if (clr_run_s) begin
      ram_addr  = ADDR_W'(clr_addr_r);
      ram_wdata = clr_color_r;
      ram_we    = 1'b1;
    end else if ((state_r == IDLE) && !empty_s && !clear_start) begin
      ram_addr  = head_addr_s;
      ram_wdata = head_data_s;
      ram_we    = 1'b1;
      pop_s     = 1'b1;
    end else begin
      ram_addr = scan_addr;
    end
  end

  // Clear engine state machine with registered busy/clear_done.
  always_ff @(posedge vclk) begin
    if (srst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
      clr_addr_r   <= 20'd0;
      clr_len_r    <= 20'd0;
      clr_color_r  <= {PIX_W{1'b0}};
    end else begin
      clear_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (clear_start) begin
            clr_color_r <= clear_color;
            clr_len_r   <= {10'd0, width} * {10'd0, height};
            clr_addr_r  <= 20'd0;
            busy_r      <= 1'b1;
`ifdef VRAM_ARB_CLEAR_SYNC_EN
            state_r     <= ARM;
`else
            state_r     <= CLEAR;
`endif
          end
        end
        ARM: begin
`ifdef VRAM_ARB_CLEAR_SYNC_EN
          if (frame_end) begin
            state_r <= CLEAR;
          end
`else
          state_r <= IDLE;
          busy_r  <= 1'b0;
`endif
        end
        CLEAR: begin
          if (clr_len_r == 20'd0) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b1;
          end else if (!visible) begin
            if (clr_addr_r == clr_len_r - 20'd1) begin
              state_r      <= IDLE;
              busy_r       <= 1'b0;
              clear_done_r <= 1'b1;
            end else begin
              clr_addr_r <= clr_addr_r + 20'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (default build).
module tb_vram_arbiter;

  logic        vclk = 1'b0;
  logic        srst;
  logic [9:0]  width, height;
  logic        visible, frame_end;
  logic [19:0] scan_addr;
  logic [2:0]  pixel;
  logic        wr_valid;
  logic [19:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ready;
  logic        clear_start;
  logic [2:0]  clear_color;
  logic        busy, clear_done;
  logic [3:0]  fifo_level;
  logic [19:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 vclk = ~vclk;

  vram_arbiter dut (
    .vclk(vclk), .srst(srst), .width(width), .height(height),
    .visible(visible), .frame_end(frame_end), .scan_addr(scan_addr),
    .pixel(pixel), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear_start(clear_start), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done), .fifo_level(fifo_level),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic tick();
    @(posedge vclk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; width = 10'd4; height = 10'd2; visible = 1'b0; frame_end = 1'b0;
    scan_addr = 20'h0; wr_valid = 1'b0; wr_addr = 20'h0; wr_data = 3'd0;
    clear_start = 1'b0; clear_color = 3'd0; ram_rdata = 3'd0;
    repeat (3) tick();
    #1;
    chk_cnt++; if (wr_ready !== 1'b0) $display("FAIL rst_wr_ready got=%0h exp=0", wr_ready); else pass_cnt++;
    chk_cnt++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we got=%0h exp=0", ram_we); else pass_cnt++;
    srst = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0h exp=0", busy); else pass_cnt++;
    chk_cnt++; if (clear_done !== 1'b0) $display("FAIL rst_done got=%0h exp=0", clear_done); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL rst_level got=%0d exp=0", fifo_level); else pass_cnt++;
    chk_cnt++; if (ram_we !== 1'b0) $display("FAIL rst_we_after got=%0h exp=0", ram_we); else pass_cnt++;
    chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL rst_ready_after got=%0h exp=1", wr_ready); else pass_cnt++;
  endtask

  task automatic test_write_visible();
    visible = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 20'h10 + 20'(i); wr_data = 3'(i + 1);
      #1;
      chk_cnt++; if (ram_we !== 1'b0) $display("FAIL wv_we_visible got=%0h exp=0", ram_we); else pass_cnt++;
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk_cnt++; if (fifo_level !== 4'd3) $display("FAIL wv_level got=%0d exp=3", fifo_level); else pass_cnt++;
    visible = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_cnt++; if (ram_we !== 1'b1) $display("FAIL wv_drain_we got=%0h exp=1", ram_we); else pass_cnt++;
      chk_cnt++; if (ram_addr !== 20'h10 + 20'(k)) $display("FAIL wv_drain_addr got=%0h exp=%0h", ram_addr, 20'h10 + 20'(k)); else pass_cnt++;
      chk_cnt++; if (ram_wdata !== 3'(k + 1)) $display("FAIL wv_drain_data got=%0d exp=%0d", ram_wdata, k + 1); else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL wv_level_end got=%0d exp=0", fifo_level); else pass_cnt++;
    chk_cnt++; if (ram_we !== 1'b0) $display("FAIL wv_we_end got=%0h exp=0", ram_we); else pass_cnt++;
  endtask

  task automatic test_full();
    visible = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_addr = 20'h20 + 20'(i); wr_data = 3'(i);
      #1;
      chk_cnt++; if (wr_ready !== (i < 8)) $display("FAIL full_ready[%0d] got=%0h exp=%0h", i, wr_ready, (i < 8)); else pass_cnt++;
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk_cnt++; if (fifo_level !== 4'd8) $display("FAIL full_level got=%0d exp=8", fifo_level); else pass_cnt++;
    tick(); #1;
    chk_cnt++; if (fifo_level !== 4'd8) $display("FAIL full_level_hold got=%0d exp=8", fifo_level); else pass_cnt++;
    chk_cnt++; if (ram_we !== 1'b0) $display("FAIL full_we_hold got=%0h exp=0", ram_we); else pass_cnt++;
    visible = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_cnt++; if (ram_we !== 1'b1 || ram_addr !== 20'h20 + 20'(k) || ram_wdata !== 3'(k))
        $display("FAIL full_drain[%0d] got=we%0h/%0h/%0d exp=we1/%0h/%0d", k, ram_we, ram_addr, ram_wdata, 20'h20 + 20'(k), k);
      else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL full_level_end got=%0d exp=0", fifo_level); else pass_cnt++;
    chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL full_ready_end got=%0h exp=1", wr_ready); else pass_cnt++;
  endtask

  task automatic test_clear();
    width = 10'd4; height = 10'd2; visible = 1'b0; clear_color = 3'd5; clear_start = 1'b1;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL clr_busy_pre got=%0h exp=0", busy); else pass_cnt++;
    tick();
    clear_start = 1'b0; clear_color = 3'd2;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_cnt++; if (ram_we !== 1'b1 || ram_addr !== 20'(k) || ram_wdata !== 3'd5 || busy !== 1'b1)
        $display("FAIL clr_write[%0d] got=we%0h/%0h/%0d/busy%0h exp=we1/%0h/5/busy1", k, ram_we, ram_addr, ram_wdata, busy, k);
      else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++; if (clear_done !== 1'b1) $display("FAIL clr_done got=%0h exp=1", clear_done); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL clr_busy_fall got=%0h exp=0", busy); else pass_cnt++;
    chk_cnt++; if (ram_we !== 1'b0) $display("FAIL clr_we_after got=%0h exp=0", ram_we); else pass_cnt++;
    tick(); #1;
    chk_cnt++; if (clear_done !== 1'b0) $display("FAIL clr_done_pulse got=%0h exp=0", clear_done); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    width = 10'd0; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b1 || ram_we !== 1'b0) $display("FAIL zero_entry got=busy%0h/we%0h exp=busy1/we0", busy, ram_we); else pass_cnt++;
    tick(); #1;
    chk_cnt++; if (clear_done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done got=done%0h/busy%0h exp=done1/busy0", clear_done, busy); else pass_cnt++;
    width = 10'd4;
  endtask

  task automatic test_clear_stall();
    clear_color = 3'd3; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_cnt++; if (ram_we !== 1'b1 || ram_addr !== 20'(k)) $display("FAIL stall_pre[%0d] got=we%0h/%0h exp=we1/%0h", k, ram_we, ram_addr, k); else pass_cnt++;
      tick();
    end
    visible = 1'b1; scan_addr = 20'h00abc;
    for (int j = 0; j < 3; j++) begin
      if (j == 1) begin clear_start = 1'b1; width = 10'd9; end
      #1;
      chk_cnt++; if (ram_we !== 1'b0 || ram_addr !== 20'h00abc) $display("FAIL stall_hold[%0d] got=we%0h/%0h exp=we0/abc", j, ram_we, ram_addr); else pass_cnt++;
      tick();
      clear_start = 1'b0;
    end
    visible = 1'b0;
    for (int k = 4; k < 8; k++) begin
      #1;
      chk_cnt++; if (ram_we !== 1'b1 || ram_addr !== 20'(k) || ram_wdata !== 3'd3)
        $display("FAIL stall_post[%0d] got=we%0h/%0h/%0d exp=we1/%0h/3", k, ram_we, ram_addr, ram_wdata, k);
      else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++; if (clear_done !== 1'b1 || ram_we !== 1'b0) $display("FAIL stall_done got=done%0h/we%0h exp=done1/we0", clear_done, ram_we); else pass_cnt++;
    width = 10'd4;
    tick();
  endtask

  task automatic test_abort();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    wr_valid = 1'b1; wr_addr = 20'h55; wr_data = 3'd1;
    tick();
    wr_valid = 1'b0;
    #1;
    chk_cnt++; if (fifo_level !== 4'd1) $display("FAIL abort_queued got=%0d exp=1", fifo_level); else pass_cnt++;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0 || fifo_level !== 4'd0) $display("FAIL abort_state got=busy%0h/lvl%0d exp=busy0/lvl0", busy, fifo_level); else pass_cnt++;
    tick(); #1;
    chk_cnt++; if (clear_done !== 1'b0 || ram_we !== 1'b0) $display("FAIL abort_nodone got=done%0h/we%0h exp=done0/we0", clear_done, ram_we); else pass_cnt++;
  endtask

  task automatic test_scan_order();
    logic [19:0] seen_addr [20];
    logic [2:0]  seen_data [20];
    int n = 0;
    visible = 1'b1; scan_addr = 20'h12345; ram_rdata = 3'd6;
    #1;
    chk_cnt++; if (ram_addr !== 20'h12345) $display("FAIL scan_addr got=%0h exp=12345", ram_addr); else pass_cnt++;
    chk_cnt++; if (pixel !== 3'd6) $display("FAIL scan_pixel got=%0d exp=6", pixel); else pass_cnt++;
    ram_rdata = 3'd1;
    #1;
    chk_cnt++; if (pixel !== 3'd1) $display("FAIL scan_pixel2 got=%0d exp=1", pixel); else pass_cnt++;
    wr_valid = 1'b1; wr_addr = 20'h1; wr_data = 3'd7;
    tick();
    wr_valid = 1'b0; clear_color = 3'd0; width = 10'd4; height = 10'd2; clear_start = 1'b1;
    tick();
    clear_start = 1'b0; visible = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ram_we === 1'b1 && n < 20) begin
        seen_addr[n] = ram_addr; seen_data[n] = ram_wdata; n++;
      end
      tick();
    end
    chk_cnt++; if (n !== 9) $display("FAIL order_count got=%0d exp=9", n); else pass_cnt++;
    for (int k = 0; k < 9; k++) begin
      chk_cnt++;
      if (seen_addr[k] !== ((k < 8) ? 20'(k) : 20'h1) || seen_data[k] !== ((k < 8) ? 3'd0 : 3'd7))
        $display("FAIL order[%0d] got=%0h/%0d exp=%0h/%0d", k, seen_addr[k], seen_data[k], (k < 8) ? k : 1, (k < 8) ? 0 : 7);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write_visible();
    test_full();
    test_clear();
    test_zero_len();
    test_clear_stall();
    test_abort();
    test_scan_order();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the test sequence");
    $fatal(1);
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Owns the single-port frame-buffer RAM and shares it between three users: scan-out reads from the VGA timing block, a queued pixel-write port for drawing logic, and an internal clear engine that fills the active area with one colour.
- Scan-out has absolute priority while `visible` is high.
- Writes and clears use blanking cycles only, so the screen never tears.
- Sits between the VGA timing block (`req_addr`/`pixel`) and the VRAM macro, in the vclk domain.

Parameters:
FIFO_DEPTH, 8, write-queue entries; power of two, minimum 2
ADDR_W, 20, VRAM address width
PIX_W, 3, pixel width (RGB bits)

Ports:
vclk  in  1  video clock
srst  in  1  synchronous reset, active-high
width  in  10  active width in pixels
height  in  10  active height in lines
visible  in  1  scan-out active, from VGA timing
frame_end  in  1  end-of-frame pulse, from VGA timing
scan_addr  in  ADDR_W  scan-out read address
pixel  out  PIX_W  scan-out read data, equal to ram_rdata
wr_valid  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  PIX_W  write pixel
wr_ready  out  1  write accepted when wr_valid && wr_ready
clear_start  in  1  single-cycle clear request
clear_color  in  PIX_W  fill colour
busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse when the clear finishes
fifo_level  out  $clog2(FIFO_DEPTH+1)  queued write count
ram_addr  out  ADDR_W  VRAM address
ram_we  out  1  VRAM write enable
ram_wdata  out  PIX_W  VRAM write data
ram_rdata  in  PIX_W  VRAM read data (1-cycle synchronous read)

Behaviour:
- Reset (srst, sync, active-high, clock vclk):
  - FIFO emptied, fifo_level=0; state IDLE; busy=0; clear_done=0.
  - While srst is high: wr_ready=0, ram_we=0.
  - Clear counter=0.
- RAM mux (combinational), in priority order:
  - visible=1: ram_addr=scan_addr, ram_we=0.
  - Else, state CLEAR: ram_addr=clr_addr, ram_wdata=clear_color (latched), ram_we=1.
  - Else, FIFO non-empty: head entry driven onto the RAM, ram_we=1, entry popped.
  - Else: ram_addr=scan_addr, ram_we=0.
- pixel=ram_rdata, passed through with no added latency.
- Write FIFO:
  - wr_ready = !full (registered occupancy). When full, no push-through even if a pop happens the same cycle.
  - Writes are accepted regardless of visible or state.
  - An entry pushed in cycle N can pop in N+1 at the earliest.
  - Strictly in order.
  - Push and pop in the same cycle leave the level unchanged.
- State machine IDLE / ARM / CLEAR:
  - IDLE, clear_start=1: latch clear_color and clr_len=width*height (20-bit product), clr_addr=0; go to CLEAR (or ARM, see Optional Feature). busy=1 from the next cycle.
  - CLEAR: each cycle with visible=0, write clr_addr and increment it. Cycles with visible=1 hold clr_addr.
  - After the write at clr_len-1: go to IDLE; clear_done=1 and busy=0 in that next cycle.
  - clr_len=0 (width or height 0): CLEAR exits immediately, zero writes, clear_done pulses one cycle after entry.
  - clear_start while busy is ignored.
  - width/height changes mid-clear are ignored (clr_len already latched).
- Ordering: FIFO entries pending when a clear starts drain after the clear, so they land on top of it.
- srst mid-clear aborts with no clear_done pulse. Queued writes are discarded.

Optional Feature:
- Macro: VRAM_ARB_CLEAR_SYNC_EN.
- Defined: clear_start moves IDLE→ARM (busy=1). ARM moves to CLEAR on the first frame_end=1, so the clear begins in the vertical blank. clear_start during ARM is ignored.
- Undefined: no ARM state; IDLE→CLEAR directly; frame_end is unused.

Decomposition:
- Package vram_pkg:
  - pix_t (PIX_W logic), addr_t (ADDR_W logic)
  - arb_state_t enum {IDLE, ARM, CLEAR}
  - localparam DEFAULT_FIFO_DEPTH=8
- Sub-module sync_fifo: parameterised width/depth; push/pop/full/empty/level; registered storage with a combinational head output.
- The arbiter is the FSM plus the RAM mux.

Test Plan:
1. Reset: srst held 3 cycles, then released → busy=0, clear_done=0, fifo_level=0, ram_we=0; wr_ready=1 in the first cycle after release.
2. Writes while visible: visible=1, push (0x10,1),(0x11,2),(0x12,3) → ram_we=0 throughout, fifo_level=3. Drop visible → three consecutive ram_we cycles with addr/data 0x10/1, 0x11/2, 0x12/3; fifo_level=0.
3. Full FIFO: visible=1, wr_valid held 10 cycles → 8 accepted, wr_ready=0, fifo_level=8, stable until visible=0; then drains in order.
4. Clear: width=4, height=2, visible=0, clear_start with clear_color=5 → ram_we with addr 0..7, data 5, over 8 cycles. Then clear_done=1 for one cycle, with busy falling in the same cycle.
5. Clear stalled: same setup, visible=1 for 3 cycles after addr 3 → no writes, addr resumes at 4; total 8 writes. clear_start pulsed mid-clear has no effect.
6. Scan pass-through and ordering:
   - visible=1, scan_addr=0x12345 → ram_addr=0x12345 that cycle; ram_rdata=6 → pixel=6.
   - Queue (0x1,7), then clear (4x2, colour 0) → all 8 clear writes precede the write to 0x1.
